// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
// Holds the request-op field layout, the access-size encodings, the
// controller state type and a helper that classifies illegal requests.
package mau_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // req_op layout: [3]=store, [2]=unsigned, [1:0]=size
    localparam int OP_STORE_BIT = 3;
    localparam int OP_UNS_BIT   = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        CAP  = 2'b10,
        WR   = 2'b11
    } state_t;

    // True when a request must be rejected without touching memory:
    // reserved size, "unsigned" store, or a misaligned half/word.
    function automatic logic op_error(input logic [3:0] op, input logic [1:0] offset);
        logic e;
        e = 1'b0;
        case (op[1:0])
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = offset[0];
            SZ_WORD: e = (offset != 2'b00);
            default: e = 1'b1;
        endcase
        if (op[OP_STORE_BIT] && op[OP_UNS_BIT]) begin
            e = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane steering for the memory access unit.
// Ports:
//   i_word    - word read from memory
//   i_offset  - byte offset within the word (little-endian lanes)
//   i_size    - access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_uns     - zero-extend (1) or sign-extend (0) loads
//   i_wdata   - right-aligned store data
//   o_load    - extracted and extended load value
//   o_merged  - i_word with the store data written into the addressed lane
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte by offset*8, half by offset[1] (upper half = bits 31:16).
    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        if (i_offset[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
    end

    // Extension of the load value and merge of store data into the read word.
    always_comb begin
        o_load   = 32'h0000_0000;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load = i_uns ? {24'h00_0000, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load = i_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
                if (i_offset[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0] = i_wdata[15:0];
                end
            end
            SZ_WORD: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
            default: begin
                o_load   = 32'h0000_0000;
                o_merged = i_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-organised data memory.
// Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word
// accesses; sub-word stores use read-modify-write; misaligned or illegal
// requests return err+done without a memory access.
// Ports:
//   CLK, RST_N            - clock, synchronous active-low reset
//   req_*                 - request handshake, op, byte address, store data
//   rdata, rdata_valid    - extended load result and its one-cycle strobe
//   done, err             - completion / rejection pulses
//   ADDR, RW_RD, din      - registered memory-side command (RW_RD=0 writes)
//   dout                  - memory read data, valid one cycle after ADDR
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  RW_RD,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout
);

    state_t                r_state;
    logic [3:0]            r_op;
    logic [1:0]            r_offset;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_rw_rd;
    logic [DATA_WIDTH-1:0] r_din;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdata_valid;
    logic                  r_done;
    logic                  r_err;

    logic [31:0]           w_load;
    logic [31:0]           w_merged;
    logic                  w_unused;

    // Upper byte-address bits are dropped on purpose: addresses wrap.
    assign w_unused = ^req_addr[31:ADDR_WIDTH+2];

    mau_lane_align u_lane_align (
        .i_word   (dout),
        .i_offset (r_offset),
        .i_size   (r_op[1:0]),
        .i_uns    (r_op[OP_UNS_BIT]),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    assign req_ready   = (r_state == IDLE) && RST_N;
    assign ADDR        = r_mem_addr;
    assign RW_RD       = r_rw_rd;
    assign din         = r_din;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign err         = r_err;

    // Controller FSM and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state       <= IDLE;
            r_op          <= 4'b0000;
            r_offset      <= 2'b00;
            r_wdata       <= '0;
            r_mem_addr    <= '0;
            r_rw_rd       <= 1'b1;
            r_din         <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_offset <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        if (op_error(req_op, req_addr[1:0])) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_mem_addr <= req_addr[ADDR_WIDTH+1:2];
                            // Full-word stores skip the read and go straight to WR.
                            if (req_op[OP_STORE_BIT] && (req_op[1:0] == SZ_WORD)) begin
                                r_din   <= req_wdata;
                                r_rw_rd <= 1'b0;
                                r_state <= WR;
                            end else begin
                                r_state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    r_state <= CAP;
                end
                CAP: begin
                    if (r_op[OP_STORE_BIT]) begin
                        r_din   <= w_merged;
                        r_rw_rd <= 1'b0;
                        r_state <= WR;
                    end else begin
                        r_rdata       <= w_load;
                        r_rdata_valid <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                WR: begin
                    r_rw_rd <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_rw_rd <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the MIPS MEM stage and the word-organised `datamemory`. It drives that memory's ADDR/RW_RD/din/dout port and converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses. Sub-word stores use read-modify-write. Misaligned requests are rejected with an error pulse and no memory access.

## Interface
- DATA_WIDTH, 32, memory word width (only 32 supported)
- ADDR_WIDTH, 10, memory word-address width; byte space is 2^(ADDR_WIDTH+2)
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high exactly when state is IDLE and RST_N=1
- req_op  in  4  [3]=store, [2]=unsigned, [1:0]=size (00 byte, 01 half, 10 word)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rdata  out  32  extended load result
- rdata_valid  out  1  one-cycle pulse with load result
- done  out  1  one-cycle pulse at completion of any accepted request
- err  out  1  one-cycle pulse with done for a rejected request
- ADDR  out  ADDR_WIDTH  word address to memory
- RW_RD  out  1  0 = write, 1 = read
- din  out  32  write data to memory
- dout  in  32  memory read data, valid the cycle after the address is presented with RW_RD=1

## Operation
- Accept on rising edge with req_valid & req_ready. Latch op, addr and wdata. Hold req_ready low while busy; the requester holds its request until accepted.
- Word address = req_addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap (0x1000 maps to word 0 when ADDR_WIDTH=10).
- Byte lanes are little-endian: offset 0 = bits 7:0, half offset 2 = bits 31:16.
- Error conditions, all with no memory access:
  - size=11;
  - store with [2]=1;
  - word access with addr[1:0]≠0;
  - half access with addr[0]≠0.
- States:
  - IDLE -> RD for loads, SB and SH; -> WR for SW; stays IDLE on error (err and done pulse next cycle).
  - RD: ADDR=word addr, RW_RD=1. -> CAP.
  - CAP: sample dout.
    - Loads: extract lane, sign- or zero-extend into rdata, -> IDLE.
    - SB/SH: merge req_wdata low byte/half into the sampled word, -> WR.
  - WR: ADDR, din=word/merged word, RW_RD=0. -> IDLE.
- All memory-side outputs are registered. RW_RD=0 occurs only in WR.
- Outside WR: RW_RD=1, and ADDR/din hold their last values.

## Timing
- Request accepted at edge E0 (cycle T).
- LB/LBU/LH/LHU/LW: RD in T+1, CAP in T+2. rdata_valid=done=1 in T+3, with req_ready=1 in T+3. Latency 3.
- SW: WR in T+1; memory writes at E1. done=1 and req_ready=1 in T+2.
- SB/SH: RD T+1, CAP T+2, WR T+3. done=1 in T+4.
- Error: err=done=1 in T+1; req_ready stays 1 throughout.
- A new request may be accepted in the same cycle that done pulses.
- rdata holds its value until the next load completes.
- Reset values: state IDLE, ADDR=0, RW_RD=1, din=0, rdata=0, rdata_valid=0, done=0, err=0.
- Reset mid-operation: abort, with no done or err.
  - A write presented in WR at the same edge that samples RST_N=0 still completes in memory.
  - No later write is issued.
  - An aborted RMW never writes.
- Requests are ignored while RST_N=0.

## Structure
- Package mau_pkg holds:
  - op field positions and size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum (IDLE, RD, CAP, WR);
  - DATA_WIDTH default.
- Sub-module mau_lane_align is combinational. Inputs: word, offset, size, unsigned, store data. Outputs: extended load value and merged store word. Shared by the CAP logic for both loads and RMW.
- Top level holds the FSM and the registered memory-side outputs.
- Bench instantiates mem_access_unit against the real datamemory.

## Test plan
- SW 0xDEADBEEF @0x010, then LW @0x010 -> ADDR=4; RW_RD=0 for exactly one cycle; rdata=0xDEADBEEF with rdata_valid 3 cycles after acceptance.
- After the above, SB 0x77 @0x012 and SH 0xA5A5 @0x010, then LW @0x010 -> 0xDE77A5A5. Each store's done comes 4 cycles after acceptance.
- Word @0x020 = 0x80FF7F01:
  - LB @0x022 -> 0xFFFFFFFF; LBU @0x022 -> 0x000000FF;
  - LH @0x022 -> 0xFFFF80FF; LHU @0x020 -> 0x00007F01.
- LW @0x011, SH @0x013, op 0011 -> err=done=1 next cycle, RW_RD stays 1, memory unchanged, req_ready never drops.
- Reset:
  - RST_N low during CAP of an SB -> RW_RD stays 1, target word unchanged, outputs at reset values.
  - RST_N low during WR of an SW -> write lands; no done.
- Wrap: SW 0x12345678 @0x1000 -> ADDR=0; LW @0x000 reads 0x12345678. Back-to-back LWs accepted on consecutive done cycles with no idle gap.
